addr_fetch: RTL and testbench
=============================

ADDR_FETCH -- requirements
Module: addr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width matching the address generator output.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter DEPTH, default 4, return-buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a frame of cfg_len reads.
REQ-007 SHALL have port cfg_len  input  16  number of addresses in the frame, sampled on start.
REQ-008 SHALL have port in_valid  input  1  upstream address valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_addr this cycle.
REQ-010 SHALL have port in_addr  input  ADDR_W  address from generator.
REQ-011 SHALL have port mem_ren  output  1  synchronous-SRAM read enable.
REQ-012 SHALL have port mem_raddr  output  ADDR_W  SRAM read address.
REQ-013 SHALL have port mem_rdata  input  DATA_W  SRAM data, valid exactly 1 cycle after mem_ren.
REQ-014 SHALL have port out_valid  output  1  out_data holds a fetched word.
REQ-015 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-016 SHALL have port out_data  output  DATA_W  fetched word, in address order.
REQ-017 SHALL have port busy  output  1  high in states RUN and DRAIN.
REQ-018 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on start (cfg_len>0); RUN->DRAIN when issued count reaches len; DRAIN->IDLE when delivered count reaches len, asserting done that same transition cycle.
REQ-020 SHALL, on start with cfg_len==0, stay IDLE, issue no reads, and pulse done the following cycle.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL drive in_ready = (state==RUN) && (issued<len) && (fifo_count + inflight < DEPTH), purely from registered state (no combinational path from in_valid or out_ready).
REQ-023 SHALL, on in_valid && in_ready, drive mem_ren=1 and mem_raddr=in_addr combinationally in the same cycle and increment issued.
REQ-024 SHALL register an inflight flag = mem_ren and, when set, push mem_rdata into the return FIFO on the next edge.
REQ-025 SHALL present FIFO head on out_data with out_valid = !empty; pop and increment delivered on out_valid && out_ready.
REQ-026 SHALL support simultaneous push and pop with count unchanged; never overflow (guaranteed by REQ-022) nor underflow.
REQ-027 SHALL sustain one address per cycle when out_ready is held high; address-to-out_valid latency is 2 cycles.
REQ-028 SHALL keep issued/delivered 16-bit, compared for equality against latched len; no wrap within a frame.
REQ-029 SHALL hold mem_raddr at 0 when mem_ren is 0.

Reset
REQ-030 SHALL, on rst, set state IDLE, issued=delivered=len=0, inflight=0, FIFO empty; outputs in_ready=0, mem_ren=0, out_valid=0, busy=0, done=0, out_data=0.
REQ-031 SHALL, on rst mid-frame, discard any in-flight return (mem_rdata in the cycle after reset is not pushed) and buffered data.
REQ-032 SHALL give rst priority over start in the same cycle.

Structure
REQ-033 SHALL place ADDR_W/DATA_W defaults, DEPTH default and the FSM state enum in shared package op_pkg.
REQ-034 SHALL implement the return buffer as sub-module fetch_fifo (synchronous, DEPTH entries, push/pop/count/empty).

Verification
REQ-035 SHALL test streaming: cfg_len=8, addrs 0..7 back-to-back, SRAM mem[a]=a+0x100, out_ready=1 -> out_data 0x100..0x107 on consecutive cycles, first 2 cycles after first accept, done once.
REQ-036 SHALL test backpressure: cfg_len=10, out_ready=0 for 12 cycles -> exactly 4 reads issued, in_ready low, no data lost after release.
REQ-037 SHALL test cfg_len=0 -> no mem_ren, done pulses 1 cycle after start, busy stays 0.
REQ-038 SHALL test reset mid-frame: rst after 3 accepts with 1 in flight -> out_valid=0 next cycle, subsequent frame of 4 returns only its own 4 words.
REQ-039 SHALL test start while busy and simultaneous push/pop at full FIFO -> start ignored, count stays DEPTH, order preserved.

Source files
------------

// File: rtl/op_pkg.sv
// Shared parameters and FSM encoding for the address-fetch datapath.
package op_pkg;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous return buffer: DEPTH entries, first-word-fall-through head.
module fetch_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && ((r_count != (PW+1)'(DEPTH)) || w_pop);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/addr_fetch.sv
// Frame-based SRAM read engine: issues addresses from the generator and
// returns fetched words in order through a small credit-limited buffer.
module addr_fetch
  import op_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_len;
  logic [15:0]       r_issued;
  logic [15:0]       r_delivered;
  logic              r_inflight;
  logic              r_zero_done;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_occ;
  logic              w_empty;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  // Occupancy counts the word still in the SRAM pipe so the buffer can never overflow.
  assign w_occ     = w_count + CW'(r_inflight);
  assign mem_ren   = in_valid && in_ready;
  assign mem_raddr = mem_ren ? in_addr : '0;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start && (cfg_len != 16'd0)) w_next_state = ST_RUN;
      ST_RUN:   if (r_issued == r_len)           w_next_state = ST_DRAIN;
      ST_DRAIN: if (r_delivered == r_len)        w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == ST_RUN) && (r_issued < r_len) && (w_occ < CW'(DEPTH));
    busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    done     = ((r_state == ST_DRAIN) && (r_delivered == r_len)) || r_zero_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_inflight  <= mem_ren;
      r_zero_done <= (r_state == ST_IDLE) && start && (cfg_len == 16'd0);
      if ((r_state == ST_IDLE) && start) begin
        r_len       <= cfg_len;
        r_issued    <= '0;
        r_delivered <= '0;
      end else begin
        if (mem_ren) r_issued    <= r_issued + 16'd1;
        if (w_pop)   r_delivered <= r_delivered + 16'd1;
      end
    end
  end

  fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (mem_rdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_addr_fetch.sv
// Directed bench for addr_fetch with a 1-cycle-latency SRAM model mem[a] = a + 0x100.
module tb_addr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_addr = '0;
  logic        mem_ren;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [15:0] got[$];
  int n_done = 0;
  int n_ren  = 0;

  always #5 clk = ~clk;

  addr_fetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always @(posedge clk) if (mem_ren) mem_rdata <= mem_raddr + 16'h0100;

  always begin
    @(negedge clk);
    #2;
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) n_done++;
    if (mem_ren) n_ren++;
  end

  task automatic clear_mon();
    got.delete();
    n_done = 0;
    n_ren  = 0;
  endtask

  task automatic start_frame(input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; cfg_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] base, input int n, input int max_cyc, output int acc);
    acc = 0;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = 1'b1;
      in_addr  = base + 16'(acc);
      #1;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = (n_done > 0);
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      #3;
      if (n_done > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (mem_ren !== 1'b0)    begin bad++; $display("FAIL reset_mem_ren got=%b want=0", mem_ren); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (out_data !== 16'h0)  begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [15:0] exp_raddr;
    clear_mon();
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; cfg_len = 16'd8;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = (k < 8);
      in_addr  = 16'(k);
      #1;
      exp_raddr = (k < 8) ? 16'(k) : 16'h0;
      total++; if (mem_ren !== (k < 8)) begin bad++; $display("FAIL stream_mem_ren k=%0d got=%b want=%b", k, mem_ren, (k < 8)); end
      total++; if (mem_raddr !== exp_raddr) begin bad++; $display("FAIL stream_mem_raddr k=%0d got=%h want=%h", k, mem_raddr, exp_raddr); end
      total++; if (out_valid !== (k >= 2 && k <= 9)) begin bad++; $display("FAIL stream_out_valid k=%0d got=%b want=%b", k, out_valid, (k >= 2 && k <= 9)); end
      if (k >= 2 && k <= 9) begin
        total++; if (out_data !== 16'h0100 + 16'(k - 2)) begin bad++; $display("FAIL stream_out_data k=%0d got=%h want=%h", k, out_data, 16'h0100 + 16'(k - 2)); end
      end
      total++; if (done !== (k == 10)) begin bad++; $display("FAIL stream_done k=%0d got=%b want=%b", k, done, (k == 10)); end
      total++; if (busy !== (k <= 10)) begin bad++; $display("FAIL stream_busy k=%0d got=%b want=%b", k, busy, (k <= 10)); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (n_done !== 1) begin bad++; $display("FAIL stream_done_count got=%0d want=1", n_done); end
    total++; if (got.size() !== 8) begin bad++; $display("FAIL stream_word_count got=%0d want=8", got.size()); end
  endtask

  task automatic test_backpressure();
    int acc;
    bit ok;
    clear_mon();
    out_ready = 1'b0;
    start_frame(16'd10);
    feed(16'h0000, 10, 12, acc);
    total++; if (acc !== 4) begin bad++; $display("FAIL bp_accepts got=%0d want=4", acc); end
    total++; if (n_ren !== 4) begin bad++; $display("FAIL bp_reads got=%0d want=4", n_ren); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    out_ready = 1'b1;
    feed(16'h0004, 6, 40, acc);
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
    total++; if (got.size() !== 10) begin bad++; $display("FAIL bp_word_count got=%0d want=10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      total++; if (got[i] !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL bp_data i=%0d got=%h want=%h", i, got[i], 16'h0100 + 16'(i)); end
    end
    total++; if (n_ren !== 10) begin bad++; $display("FAIL bp_total_reads got=%0d want=10", n_ren); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    @(negedge clk);
    start = 1'b1; cfg_len = 16'd0; in_valid = 1'b1; in_addr = 16'h0005;
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_early got=%b want=0", done); end
    @(negedge clk);
    start = 1'b0;
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", busy); end
    total++; if (mem_ren !== 1'b0) begin bad++; $display("FAIL zero_mem_ren got=%b want=0", mem_ren); end
    @(negedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%b want=0", busy); end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (n_ren !== 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", n_ren); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", n_done); end
  endtask

  task automatic test_reset_midframe();
    int acc;
    bit ok;
    out_ready = 1'b0;
    start_frame(16'd8);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = 1'b1; in_addr = 16'h0010 + 16'(k);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b want=1", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_stale got=%b want=0", out_valid); end
    clear_mon();
    out_ready = 1'b1;
    start_frame(16'd4);
    feed(16'h0020, 4, 20, acc);
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_done_timeout got=0 want=1"); end
    repeat (3) @(negedge clk);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL rstmid_word_count got=%0d want=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++; if (got[i] !== 16'h0120 + 16'(i)) begin bad++; $display("FAIL rstmid_data i=%0d got=%h want=%h", i, got[i], 16'h0120 + 16'(i)); end
    end
  endtask

  task automatic test_start_busy_full();
    int acc;
    bit ok;
    clear_mon();
    out_ready = 1'b0;
    start_frame(16'd6);
    feed(16'h0040, 6, 8, acc);
    total++; if (acc !== 4) begin bad++; $display("FAIL full_accepts got=%0d want=4", acc); end
    start = 1'b1; cfg_len = 16'd2;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b want=1", busy); end
    @(negedge clk);
    start = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b want=0", in_ready); end
    out_ready = 1'b1;
    feed(16'h0044, 2, 20, acc);
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_done_timeout got=0 want=1"); end
    repeat (2) @(negedge clk);
    total++; if (got.size() !== 6) begin bad++; $display("FAIL full_word_count got=%0d want=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      total++; if (got[i] !== 16'h0140 + 16'(i)) begin bad++; $display("FAIL full_data i=%0d got=%h want=%h", i, got[i], 16'h0140 + 16'(i)); end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL full_done_count got=%0d want=1", n_done); end
    total++; if (n_ren !== 6) begin bad++; $display("FAIL full_reads got=%0d want=6", n_ren); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_zero_len();
    test_reset_midframe();
    test_start_busy_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
